nv_nvdla_cacc_multi_reg: RTL and testbench

Parametrised CACC configuration register file holding NUM_GROUPS independent register groups. Software programs groups in a ring through a producer pointer; the accumulator datapath executes groups in order through a consumer pointer. Per-group op_en, write-lock and saturation counting let software program layer N+1..N+k while layer N runs. It sits between the CSB register slave and the CACC datapath and replaces the fixed two-group arrangement.

---
 rtl/nv_nvdla_cacc_reg_pkg.sv | 137 +++++++++++++
 rtl/nv_nvdla_cacc_reg_group.sv | 73 +++++++
 rtl/nv_nvdla_cacc_multi_reg.sv | 153 +++++++++++++++
 tb/tb_nv_nvdla_cacc_multi_reg.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_cacc_reg_pkg.sv
// Shared definitions for the CACC multi-group register file: CSB offsets,
// field widths/positions, reset values, the group-field payload struct and
// the per-group register read/write helpers.
package nv_nvdla_cacc_reg_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SAT_W  = 32;

  localparam logic [ADDR_W-1:0] OFS_POINTER      = 12'h004;
  localparam logic [ADDR_W-1:0] OFS_OP_ENABLE    = 12'h008;
  localparam logic [ADDR_W-1:0] OFS_MISC_CFG     = 12'h00c;
  localparam logic [ADDR_W-1:0] OFS_DATAOUT_SZ0  = 12'h010;
  localparam logic [ADDR_W-1:0] OFS_DATAOUT_SZ1  = 12'h014;
  localparam logic [ADDR_W-1:0] OFS_DATAOUT_ADDR = 12'h018;
  localparam logic [ADDR_W-1:0] OFS_BATCH_NUMBER = 12'h01c;
  localparam logic [ADDR_W-1:0] OFS_LINE_STRIDE  = 12'h020;
  localparam logic [ADDR_W-1:0] OFS_SURF_STRIDE  = 12'h024;
  localparam logic [ADDR_W-1:0] OFS_DATAOUT_MAP  = 12'h028;
  localparam logic [ADDR_W-1:0] OFS_CLIP_CFG     = 12'h02c;
  localparam logic [ADDR_W-1:0] OFS_OUT_SAT      = 12'h030;
  localparam logic [ADDR_W-1:0] OFS_CYA          = 12'h034;

  localparam int unsigned CONV_MODE_W = 1;
  localparam int unsigned PREC_W      = 2;
  localparam int unsigned SIZE_W      = 13;
  localparam int unsigned BATCH_W     = 5;
  localparam int unsigned STRIDE_W    = 24;
  localparam int unsigned CLIP_W      = 5;

  localparam int unsigned CONV_MODE_LSB   = 0;
  localparam int unsigned PREC_LSB        = 12;
  localparam int unsigned WIDTH_LSB       = 0;
  localparam int unsigned HEIGHT_LSB      = 16;
  localparam int unsigned CHANNEL_LSB     = 0;
  localparam int unsigned BATCH_LSB       = 0;
  localparam int unsigned STRIDE_LSB      = 0;
  localparam int unsigned LINE_PACKED_LSB = 0;
  localparam int unsigned SURF_PACKED_LSB = 16;
  localparam int unsigned CLIP_LSB        = 0;

  localparam logic [PREC_W-1:0] PREC_RST = 2'b01;

  typedef struct packed {
    logic                   conv_mode;
    logic [PREC_W-1:0]      proc_precision;
    logic [SIZE_W-1:0]      dataout_width;
    logic [SIZE_W-1:0]      dataout_height;
    logic [SIZE_W-1:0]      dataout_channel;
    logic [DATA_W-1:0]      dataout_addr;
    logic [BATCH_W-1:0]     batches;
    logic [STRIDE_W-1:0]    line_stride;
    logic [STRIDE_W-1:0]    surf_stride;
    logic                   line_packed;
    logic                   surf_packed;
    logic [CLIP_W-1:0]      clip_truncate;
    logic [DATA_W-1:0]      cya;
  } cacc_grp_fields_t;

  localparam cacc_grp_fields_t GRP_FIELDS_RST = '{
    conv_mode: 1'b0, proc_precision: PREC_RST,
    dataout_width: '0, dataout_height: '0, dataout_channel: '0,
    dataout_addr: '0, batches: '0, line_stride: '0, surf_stride: '0,
    line_packed: 1'b0, surf_packed: 1'b0, clip_truncate: '0, cya: '0};

  // Writable per-group field registers (OUT_SATURATION is read-only).
  function automatic logic is_grp_wr_ofs(input logic [ADDR_W-1:0] ofs);
    case (ofs)
      OFS_MISC_CFG, OFS_DATAOUT_SZ0, OFS_DATAOUT_SZ1, OFS_DATAOUT_ADDR,
      OFS_BATCH_NUMBER, OFS_LINE_STRIDE, OFS_SURF_STRIDE, OFS_DATAOUT_MAP,
      OFS_CLIP_CFG, OFS_CYA: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  // Apply one CSB write to a group's fields; unmapped offsets leave it as is.
  function automatic cacc_grp_fields_t grp_write(input cacc_grp_fields_t f,
                                                 input logic [ADDR_W-1:0] ofs,
                                                 input logic [DATA_W-1:0] d);
    cacc_grp_fields_t n;
    n = f;
    case (ofs)
      OFS_MISC_CFG: begin
        n.conv_mode      = d[CONV_MODE_LSB];
        n.proc_precision = d[PREC_LSB +: PREC_W];
      end
      OFS_DATAOUT_SZ0: begin
        n.dataout_width  = d[WIDTH_LSB +: SIZE_W];
        n.dataout_height = d[HEIGHT_LSB +: SIZE_W];
      end
      OFS_DATAOUT_SZ1:  n.dataout_channel = d[CHANNEL_LSB +: SIZE_W];
      OFS_DATAOUT_ADDR: n.dataout_addr    = d;
      OFS_BATCH_NUMBER: n.batches         = d[BATCH_LSB +: BATCH_W];
      OFS_LINE_STRIDE:  n.line_stride     = d[STRIDE_LSB +: STRIDE_W];
      OFS_SURF_STRIDE:  n.surf_stride     = d[STRIDE_LSB +: STRIDE_W];
      OFS_DATAOUT_MAP: begin
        n.line_packed = d[LINE_PACKED_LSB];
        n.surf_packed = d[SURF_PACKED_LSB];
      end
      OFS_CLIP_CFG:     n.clip_truncate   = d[CLIP_LSB +: CLIP_W];
      OFS_CYA:          n.cya             = d;
      default: ;
    endcase
    return n;
  endfunction

  // Read image of a group's field register; unmapped offsets read zero.
  function automatic logic [DATA_W-1:0] grp_read(input cacc_grp_fields_t f,
                                                 input logic [ADDR_W-1:0] ofs);
    logic [DATA_W-1:0] r;
    r = '0;
    case (ofs)
      OFS_MISC_CFG: begin
        r[CONV_MODE_LSB]          = f.conv_mode;
        r[PREC_LSB +: PREC_W]     = f.proc_precision;
      end
      OFS_DATAOUT_SZ0: begin
        r[WIDTH_LSB +: SIZE_W]    = f.dataout_width;
        r[HEIGHT_LSB +: SIZE_W]   = f.dataout_height;
      end
      OFS_DATAOUT_SZ1:  r[CHANNEL_LSB +: SIZE_W]  = f.dataout_channel;
      OFS_DATAOUT_ADDR: r                         = f.dataout_addr;
      OFS_BATCH_NUMBER: r[BATCH_LSB +: BATCH_W]   = f.batches;
      OFS_LINE_STRIDE:  r[STRIDE_LSB +: STRIDE_W] = f.line_stride;
      OFS_SURF_STRIDE:  r[STRIDE_LSB +: STRIDE_W] = f.surf_stride;
      OFS_DATAOUT_MAP: begin
        r[LINE_PACKED_LSB]        = f.line_packed;
        r[SURF_PACKED_LSB]        = f.surf_packed;
      end
      OFS_CLIP_CFG:     r[CLIP_LSB +: CLIP_W]     = f.clip_truncate;
      OFS_CYA:          r                         = f.cya;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nv_nvdla_cacc_reg_group.sv
// One CACC register group: configuration fields, op_en and a saturating
// saturation counter.
//   clk, rstn        : core clock, synchronous active-low reset
//   fld_wr_en_i      : field write aimed at this group (dropped while op_en=1)
//   wr_ofs_i/data_i  : CSB offset and write data
//   op_set_i         : OP_ENABLE=1 write aimed at this group
//   done_i           : layer finished on this group (clears op_en)
//   sat_sel_i        : this group is the consumer; counts sat_inc_i while op_en
//   fields_o, op_en_o, sat_count_o : registered group state
module nv_nvdla_cacc_reg_group
  import nv_nvdla_cacc_reg_pkg::*;
#(
  parameter int unsigned SAT_INC_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fld_wr_en_i,
  input  logic [ADDR_W-1:0]     wr_ofs_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  op_set_i,
  input  logic                  done_i,
  input  logic                  sat_sel_i,
  input  logic [SAT_INC_W-1:0]  sat_inc_i,
  output cacc_grp_fields_t      fields_o,
  output logic                  op_en_o,
  output logic [SAT_W-1:0]      sat_count_o
);

  localparam int unsigned SUM_W = SAT_W + 1;

  cacc_grp_fields_t   fields_q, fields_d;
  logic               op_en_q, op_en_d;
  logic [SAT_W-1:0]   sat_count_q, sat_count_d;
  logic [SUM_W-1:0]   sat_sum;

  // Next-state: locked field writes, saturating count; a set beats a done.
  always_comb begin
    fields_d    = fields_q;
    op_en_d     = op_en_q;
    sat_count_d = sat_count_q;
    sat_sum     = {1'b0, sat_count_q} + SUM_W'(sat_inc_i);
    if (fld_wr_en_i && !op_en_q) begin
      fields_d = grp_write(fields_q, wr_ofs_i, wr_data_i);
    end
    if (sat_sel_i && op_en_q) begin
      sat_count_d = sat_sum[SAT_W] ? '1 : sat_sum[SAT_W-1:0];
    end
    if (done_i) begin
      op_en_d = 1'b0;
    end
    if (op_set_i) begin
      op_en_d     = 1'b1;
      sat_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fields_q    <= GRP_FIELDS_RST;
      op_en_q     <= 1'b0;
      sat_count_q <= '0;
    end else begin
      fields_q    <= fields_d;
      op_en_q     <= op_en_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign fields_o    = fields_q;
  assign op_en_o     = op_en_q;
  assign sat_count_o = sat_count_q;

endmodule

// File: rtl/nv_nvdla_cacc_multi_reg.sv
// CACC configuration register file with NUM_GROUPS groups in a ring.
// Software programs group[producer]; the datapath runs group[consumer].
//   nvdla_core_clk/rstn : clock, synchronous active-low reset
//   reg_*               : CSB write port and combinational read data
//   dp_done, sat_inc    : datapath layer-done pulse and saturation increment
//   dp_op_en, dp_group and field outputs : consumer-group state
module nv_nvdla_cacc_multi_reg
  import nv_nvdla_cacc_reg_pkg::*;
#(
  parameter int unsigned NUM_GROUPS = 2,
  parameter int unsigned PTR_W      = 3,
  parameter int unsigned SAT_INC_W  = 8
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic [ADDR_W-1:0]     reg_offset,
  input  logic [DATA_W-1:0]     reg_wr_data,
  input  logic                  reg_wr_en,
  output logic [DATA_W-1:0]     reg_rd_data,
  input  logic                  dp_done,
  input  logic [SAT_INC_W-1:0]  sat_inc,
  output logic                  dp_op_en,
  output logic [PTR_W-1:0]      dp_group,
  output logic [BATCH_W-1:0]    batches,
  output logic [CLIP_W-1:0]     clip_truncate,
  output logic [DATA_W-1:0]     dataout_addr,
  output logic [DATA_W-1:0]     cya,
  output logic [SIZE_W-1:0]     dataout_width,
  output logic [SIZE_W-1:0]     dataout_height,
  output logic [SIZE_W-1:0]     dataout_channel,
  output logic [STRIDE_W-1:0]   line_stride,
  output logic [STRIDE_W-1:0]   surf_stride,
  output logic                  line_packed,
  output logic                  surf_packed,
  output logic                  conv_mode,
  output logic [PREC_W-1:0]     proc_precision
);

  logic [PTR_W-1:0]       producer_q, producer_d;
  logic [PTR_W-1:0]       consumer_q, consumer_d;

  cacc_grp_fields_t       grp_fields [NUM_GROUPS];
  logic [SAT_W-1:0]       grp_sat    [NUM_GROUPS];
  logic [NUM_GROUPS-1:0]  grp_op_en;

  cacc_grp_fields_t       prod_fields, cons_fields;
  logic                   prod_op_en, cons_op_en;
  logic [SAT_W-1:0]       prod_sat;

  logic                   ptr_wr, op_set, fld_wr, done_ok;

  assign ptr_wr  = reg_wr_en && (reg_offset == OFS_POINTER);
  assign op_set  = reg_wr_en && (reg_offset == OFS_OP_ENABLE) && reg_wr_data[0];
  assign fld_wr  = reg_wr_en && is_grp_wr_ofs(reg_offset);
  assign done_ok = dp_done && cons_op_en;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    logic is_prod, is_cons;
    assign is_prod = (producer_q == PTR_W'(g));
    assign is_cons = (consumer_q == PTR_W'(g));

    nv_nvdla_cacc_reg_group #(
      .SAT_INC_W (SAT_INC_W)
    ) u_group (
      .clk         (nvdla_core_clk),
      .rstn        (nvdla_core_rstn),
      .fld_wr_en_i (fld_wr && is_prod),
      .wr_ofs_i    (reg_offset),
      .wr_data_i   (reg_wr_data),
      .op_set_i    (op_set && is_prod),
      .done_i      (done_ok && is_cons),
      .sat_sel_i   (is_cons),
      .sat_inc_i   (sat_inc),
      .fields_o    (grp_fields[g]),
      .op_en_o     (grp_op_en[g]),
      .sat_count_o (grp_sat[g])
    );
  end

  // Producer / consumer group selection.
  always_comb begin
    prod_fields = '0;
    prod_op_en  = 1'b0;
    prod_sat    = '0;
    cons_fields = '0;
    cons_op_en  = 1'b0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      if (producer_q == PTR_W'(g)) begin
        prod_fields = grp_fields[g];
        prod_op_en  = grp_op_en[g];
        prod_sat    = grp_sat[g];
      end
      if (consumer_q == PTR_W'(g)) begin
        cons_fields = grp_fields[g];
        cons_op_en  = grp_op_en[g];
      end
    end
  end

  // Pointer next-state; written producer wraps modulo NUM_GROUPS.
  always_comb begin
    producer_d = producer_q;
    consumer_d = consumer_q;
    if (ptr_wr) begin
      producer_d = PTR_W'(32'(reg_wr_data[PTR_W-1:0]) % NUM_GROUPS);
    end
    if (done_ok) begin
      consumer_d = (consumer_q == PTR_W'(NUM_GROUPS - 1)) ? '0
                                                          : consumer_q + PTR_W'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      producer_q <= '0;
      consumer_q <= '0;
    end else begin
      producer_q <= producer_d;
      consumer_q <= consumer_d;
    end
  end

  // CSB read mux.
  always_comb begin
    reg_rd_data = '0;
    case (reg_offset)
      OFS_POINTER: begin
        reg_rd_data[PTR_W-1:0]  = producer_q;
        reg_rd_data[16 +: PTR_W] = consumer_q;
      end
      OFS_OP_ENABLE: reg_rd_data[0] = prod_op_en;
      OFS_OUT_SAT:   reg_rd_data    = prod_sat;
      default:       reg_rd_data    = grp_read(prod_fields, reg_offset);
    endcase
  end

  assign dp_op_en        = cons_op_en;
  assign dp_group        = consumer_q;
  assign batches         = cons_fields.batches;
  assign clip_truncate   = cons_fields.clip_truncate;
  assign dataout_addr    = cons_fields.dataout_addr;
  assign cya             = cons_fields.cya;
  assign dataout_width   = cons_fields.dataout_width;
  assign dataout_height  = cons_fields.dataout_height;
  assign dataout_channel = cons_fields.dataout_channel;
  assign line_stride     = cons_fields.line_stride;
  assign surf_stride     = cons_fields.surf_stride;
  assign line_packed     = cons_fields.line_packed;
  assign surf_packed     = cons_fields.surf_packed;
  assign conv_mode       = cons_fields.conv_mode;
  assign proc_precision  = cons_fields.proc_precision;

endmodule

// File: tb/tb_nv_nvdla_cacc_multi_reg.sv
// Scoreboard bench for nv_nvdla_cacc_multi_reg (3 groups, wide sat_inc so
// the saturation ceiling is reachable in a few hundred cycles).
module tb_nv_nvdla_cacc_multi_reg;

  localparam int unsigned NG = 3;
  localparam int unsigned PW = 3;
  localparam int unsigned SW = 24;
  localparam int unsigned OW = 170;

  logic            clk;
  logic            rstn;
  logic [11:0]     reg_offset;
  logic [31:0]     reg_wr_data;
  logic            reg_wr_en;
  logic [31:0]     reg_rd_data;
  logic            dp_done;
  logic [SW-1:0]   sat_inc;
  logic            dp_op_en;
  logic [PW-1:0]   dp_group;
  logic [4:0]      batches, clip_truncate;
  logic [31:0]     dataout_addr, cya;
  logic [12:0]     dataout_width, dataout_height, dataout_channel;
  logic [23:0]     line_stride, surf_stride;
  logic            line_packed, surf_packed, conv_mode;
  logic [1:0]      proc_precision;

  nv_nvdla_cacc_multi_reg #(
    .NUM_GROUPS (NG), .PTR_W (PW), .SAT_INC_W (SW)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .reg_offset      (reg_offset),
    .reg_wr_data     (reg_wr_data),
    .reg_wr_en       (reg_wr_en),
    .reg_rd_data     (reg_rd_data),
    .dp_done         (dp_done),
    .sat_inc         (sat_inc),
    .dp_op_en        (dp_op_en),
    .dp_group        (dp_group),
    .batches         (batches),
    .clip_truncate   (clip_truncate),
    .dataout_addr    (dataout_addr),
    .cya             (cya),
    .dataout_width   (dataout_width),
    .dataout_height  (dataout_height),
    .dataout_channel (dataout_channel),
    .line_stride     (line_stride),
    .surf_stride     (surf_stride),
    .line_packed     (line_packed),
    .surf_packed     (surf_packed),
    .conv_mode       (conv_mode),
    .proc_precision  (proc_precision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit              is_out;
    string           name;
    logic [OW-1:0]   exp;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  exp_t          mon_e;
  logic [OW-1:0] mon_act;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.is_out)
        mon_act = {dp_op_en, dp_group, batches, clip_truncate, dataout_addr, cya,
                   dataout_width, dataout_height, dataout_channel,
                   line_stride, surf_stride, line_packed, surf_packed,
                   conv_mode, proc_precision};
      else
        mon_act = OW'(reg_rd_data);
      n_checks++;
      if (mon_act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s at %0t: got %h required %h", mon_e.name, $time, mon_act, mon_e.exp);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0]     m_reg [NG][16];
  bit              m_op  [NG];
  longint unsigned m_sat [NG];
  int              m_prod, m_cons;
  bit              m_valid = 1'b0;

  function automatic logic [31:0] fmask(input logic [11:0] off);
    case (off)
      12'h00c: return 32'h0000_3001;
      12'h010: return 32'h1FFF_1FFF;
      12'h014: return 32'h0000_1FFF;
      12'h018: return 32'hFFFF_FFFF;
      12'h01c: return 32'h0000_001F;
      12'h020: return 32'h00FF_FFFF;
      12'h024: return 32'h00FF_FFFF;
      12'h028: return 32'h0001_0001;
      12'h02c: return 32'h0000_001F;
      12'h034: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] off);
    if (off == 12'h004) return (32'(m_cons) << 16) | 32'(m_prod);
    if (off == 12'h008) return {31'b0, m_op[m_prod]};
    if (off == 12'h030) return m_sat[m_prod][31:0];
    if (fmask(off) != 0) return m_reg[m_prod][off[5:2]];
    return 32'h0;
  endfunction

  function automatic logic [OW-1:0] m_outs();
    logic [31:0] r [16];
    r = m_reg[m_cons];
    return {m_op[m_cons], PW'(m_cons), r[7][4:0], r[11][4:0], r[6], r[13],
            r[4][12:0], r[4][28:16], r[5][12:0], r[8][23:0], r[9][23:0],
            r[10][0], r[10][16], r[3][0], r[3][13:12]};
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin
      for (int i = 0; i < 16; i++) m_reg[g][i] = 32'h0;
      m_reg[g][3] = 32'h0000_1000;
      m_op[g]  = 1'b0;
      m_sat[g] = 0;
    end
    m_prod = 0;
    m_cons = 0;
  endtask

  task automatic model_edge(input bit we, input logic [11:0] off, input logic [31:0] d,
                            input bit done, input logic [SW-1:0] inc);
    bit lock, run;
    int p;
    longint unsigned s;
    p    = m_prod;
    lock = m_op[m_prod];
    run  = m_op[m_cons];
    if (run) begin
      s = m_sat[m_cons] + longint'(inc);
      m_sat[m_cons] = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
    end
    if (done && run) begin
      m_op[m_cons] = 1'b0;
      m_cons = (m_cons + 1) % NG;
    end
    if (we) begin
      if (off == 12'h004) m_prod = int'(d[2:0]) % NG;
      if (off == 12'h008 && d[0]) begin
        m_op[p]  = 1'b1;
        m_sat[p] = 0;
      end
      if (fmask(off) != 0 && !lock) m_reg[p][off[5:2]] = d & fmask(off);
    end
  endtask

  // One clock cycle: drive inputs, queue expectations from pre-edge model
  // state, then advance the model across the coming edge.
  task automatic step(input bit rst, input bit we, input logic [11:0] off,
                      input logic [31:0] d, input bit done, input logic [SW-1:0] inc);
    exp_t e;
    rstn        = !rst;
    reg_wr_en   = we;
    reg_offset  = off;
    reg_wr_data = d;
    dp_done     = done;
    sat_inc     = inc;
    if (m_valid) begin
      e.is_out = 1'b0; e.name = $sformatf("rd_%03h", off); e.exp = OW'(m_read(off));
      sb_q.push_back(e);
      e.is_out = 1'b1; e.name = "dp_outs"; e.exp = m_outs();
      sb_q.push_back(e);
    end
    if (rst) begin
      model_reset();
      m_valid = 1'b1;
    end else if (m_valid) begin
      model_edge(we, off, d, done, inc);
    end
    @(posedge clk);
    #1;
  endtask

  logic [11:0] ofs_tab [16] = '{12'h000, 12'h004, 12'h008, 12'h00c, 12'h010, 12'h014,
                                12'h018, 12'h01c, 12'h020, 12'h024, 12'h028, 12'h02c,
                                12'h030, 12'h034, 12'h038, 12'h031};

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; reg_wr_en = 1'b0; reg_offset = '0; reg_wr_data = '0;
    dp_done = 1'b0; sat_inc = '0;

    // reset and full-map readback
    step(1, 0, 12'h000, 0, 0, 0);
    step(1, 0, 12'h000, 0, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 12'(i * 4), 0, 0, 0);
    step(0, 0, 12'hffc, 0, 0, 0);

    // group0 program, enable, locked rewrite
    step(0, 1, 12'h010, 32'h20, 0, 0);
    step(0, 1, 12'h008, 32'h1, 0, 0);
    step(0, 0, 12'h010, 0, 0, 0);
    step(0, 1, 12'h010, 32'h40, 0, 0);
    step(0, 0, 12'h010, 0, 0, 0);

    // groups 1 and 2 (pointer 5 wraps to 2)
    step(0, 1, 12'h004, 32'h1, 0, 0);
    step(0, 1, 12'h018, 32'hDEAD_BEEF, 0, 0);
    step(0, 1, 12'h00c, 32'hFFFF_FFFF, 0, 0);
    step(0, 1, 12'h008, 32'h1, 0, 0);
    step(0, 1, 12'h004, 32'h5, 0, 0);
    step(0, 1, 12'h028, 32'hFFFF_FFFF, 0, 0);
    step(0, 1, 12'h020, 32'h0012_3456, 0, 0);
    step(0, 1, 12'h008, 32'h1, 0, 0);
    step(0, 0, 12'h004, 0, 0, 0);

    // walk the ring; a final done with nothing enabled is ignored
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 12'h004, 0, 1, 0);
      step(0, 0, 12'h004, 0, 0, 0);
    end

    // OP_ENABLE write and dp_done on the same group in one cycle
    step(0, 1, 12'h004, 32'h0, 0, 0);
    step(0, 1, 12'h008, 32'h1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 12'h030, 0, 0, 5);
    step(0, 1, 12'h008, 32'h1, 1, 7);
    step(0, 0, 12'h008, 0, 0, 0);
    step(0, 0, 12'h030, 0, 0, 0);
    step(0, 0, 12'h004, 0, 0, 0);

    // saturation on group1
    step(0, 1, 12'h004, 32'h1, 0, 0);
    step(0, 1, 12'h008, 32'h1, 0, 0);
    for (int k = 0; k < 300; k++) step(0, 0, 12'h030, 0, 0, 24'hFF_FFFF);

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      logic [11:0] o;
      logic [31:0] d;
      logic [SW-1:0] inc;
      o   = ofs_tab[$urandom_range(0, 15)];
      d   = $urandom();
      if (o == 12'h008) d[0] = ($urandom_range(0, 3) != 0);
      inc = ($urandom_range(0, 7) == 0) ? SW'($urandom()) : SW'($urandom_range(0, 15));
      step(0, ($urandom_range(0, 1) == 1), o, d, ($urandom_range(0, 5) == 0), inc);
    end

    // reset mid-layer with the consumer running
    step(0, 1, 12'h004, 32'(m_cons), 0, 0);
    step(0, 1, 12'h008, 32'h1, 0, 0);
    step(0, 0, 12'h030, 0, 0, 3);
    step(1, 0, 12'h008, 0, 0, 3);
    step(0, 0, 12'h004, 0, 0, 0);
    step(0, 0, 12'h008, 0, 0, 0);
    step(0, 0, 12'h00c, 0, 0, 0);
    step(0, 0, 12'h030, 0, 0, 0);

    @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
